dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//   In-order dispatch sequencer between instruction fetch and the Decoder.
//   - Buffers fetched instructions in a small queue.
//   - Asserts the decoder enable only when the target reservation station (ALU/LS/branch) and the ROB can accept.
//   - Stops fetch past any control-flow instruction and issues exactly one PC redirect once its target is known.
// PARAMETERS
//   QDEPTH  4   instruction queue entries (power of 2, >=2)
//   INST_W  32  instruction width (`instWidth)
//   ADDR_W  32  PC width (`addrWidth)
// PORTS
//   clk                input   1       rising-edge clock
//   rst_n              input   1       async active-low reset
//   fetch_valid        input   1       fetch offers fetch_inst/fetch_pc
//   fetch_inst         input   INST_W  fetched instruction
//   fetch_pc           input   ADDR_W  its PC
//   fetch_ready        output  1       queue accepts this cycle
//   dec_enable         output  1       drives Decoder decoderEnable (dispatch fires)
//   dec_inst           output  INST_W  queue head instruction
//   dec_pc             output  ADDR_W  queue head PC
//   rob_full           input   1       ROB cannot allocate
//   alu_rs_full        input   1       ALU RS full
//   ls_rs_full         input   1       load/store RS full
//   br_rs_full         input   1       branch RS full
//   branch_dest_valid  input   1       Decoder resolved branch at dispatch
//   branch_dest        input   ADDR_W  Decoder-resolved target
//   ctrl_resolve_valid input   1       branch unit/ALU resolved pending control inst
//   ctrl_resolve_dest  input   ADDR_W  resolved target
//   redirect_valid     output  1       one-cycle PC redirect pulse
//   redirect_pc        output  ADDR_W  new fetch PC
//   ctrl_pending       output  1       control inst dispatched, target unknown
// BEHAVIOUR
//   Reset: queue empty, state RUN, ctrl_in_q=0; fetch_ready=1, dec_enable=0, redirect_valid=0, redirect_pc=0, ctrl_pending=0.
//   Queue and enqueue:
//     - Circular queue; head/tail pointers wrap modulo QDEPTH; count 0..QDEPTH.
//     - Enqueue on fetch_valid&&fetch_ready; an entry is dispatchable the cycle after its write (no bypass).
//   Control-flow = opcode inst[6:0] in {1100011 branch, 1101111 JAL, 1100111 JALR}:
//     - Enqueuing one sets ctrl_in_q.
//     - fetch_ready = (count<QDEPTH) && !ctrl_in_q && state==RUN.
//   Target unit by opcode:
//     - branch -> BR, needs !br_rs_full.
//     - load 0000011 -> LS, needs !ls_rs_full && !rob_full.
//     - store 0100011 -> LS, needs !ls_rs_full only.
//     - all other opcodes -> ALU, needs !alu_rs_full && !rob_full.
//   dec_enable = (count!=0) && state==RUN && unit condition met; combinational from registered state and full flags. Head pops on the same edge.
//   Nop (0x00000013) dispatches normally through the ALU path.
//   FSM:
//     RUN: head control inst dispatched ->
//       - branch with branch_dest_valid=1 -> REDIR; redirect_pc<=branch_dest.
//       - otherwise -> WAIT; ctrl_pending=1.
//     WAIT: no dispatch, no fetch; on ctrl_resolve_valid -> REDIR, redirect_pc<=ctrl_resolve_dest.
//       ctrl_resolve_valid in RUN/REDIR is ignored.
//     REDIR: redirect_valid=1 for exactly one cycle; clears ctrl_in_q and ctrl_pending -> RUN.
//       Queue is empty here: a control inst is always the youngest entry.
//   Fetch side:
//     - fetch_ready=0 in WAIT/REDIR.
//     - fetch_valid while !fetch_ready is dropped; fetch must hold it.
//   Simultaneous enqueue+dispatch: count unchanged, both pointers advance. Full queue with a dispatch still rejects the enqueue that cycle.
//   rst_n assertion mid-WAIT or mid-REDIR: immediate return to reset values; no redirect issued.
// CONFIGURATION
//   DISPATCH_PERF_EN defined:
//     - Adds outputs stall_rob_cnt, stall_rs_cnt, stall_ctrl_cnt [31:0]; each saturates at 0xFFFFFFFF and resets to 0.
//     - stall_rob_cnt: cycles blocked by rob_full.
//     - stall_rs_cnt: cycles blocked by the target RS full.
//     - stall_ctrl_cnt: cycles spent in WAIT.
//   Undefined: counters and ports absent; dispatch behaviour identical.
// TESTING
//   1 Enqueue 4 ALU insts back-to-back, all full flags 0 -> dec_enable high cycles 2..5, fetch_ready=1 throughout, count returns to 0.
//   2 Fill queue with rob_full=1 -> fetch_ready=0 at count=4; store at head dispatches anyway, then loads stall until rob_full=0.
//   3 BEQ at head with branch_dest_valid=1, branch_dest=0x100 -> next cycle redirect_valid=1, redirect_pc=0x100, then RUN, fetch_ready=1.
//   4 JALR dispatched -> WAIT, fetch_ready=0 and dec_enable=0 for 10 cycles; ctrl_resolve_valid with dest 0x2C -> one redirect pulse, pc=0x2C.
//   5 Enqueue after BNE in queue -> rejected until redirect; ctrl_resolve_valid while in RUN -> ignored.
//   6 rst_n low in WAIT -> all outputs at reset values; after release, enqueue at ptr 0; with DISPATCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// In-order dispatch sequencer: small instruction queue, per-unit dispatch gating, fetch stop and PC redirect
// around control-flow instructions. Define DISPATCH_PERF_EN to add saturating stall counters.
module dispatch_ctrl #(
  parameter int QDEPTH = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [INST_W-1:0] fetch_inst,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              dec_enable,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              rob_full,
  input  logic              alu_rs_full,
  input  logic              ls_rs_full,
  input  logic              br_rs_full,
  input  logic              branch_dest_valid,
  input  logic [ADDR_W-1:0] branch_dest,
  input  logic              ctrl_resolve_valid,
  input  logic [ADDR_W-1:0] ctrl_resolve_dest,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              ctrl_pending
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]       stall_rob_cnt,
  output logic [31:0]       stall_rs_cnt,
  output logic [31:0]       stall_ctrl_cnt
`endif
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_REDIR} state_t;

  logic [INST_W-1:0] inst_mem [QDEPTH];
  logic [ADDR_W-1:0] pc_mem   [QDEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q;
  logic              ctrl_in_q;
  logic              redirect_valid_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              ctrl_pending_q;

  logic [6:0] head_op;
  logic       head_is_ctrl;
  logic       head_is_br;
  logic       head_needs_rob;
  logic       head_rs_full;
  logic       unit_ok;
  logic       fetch_is_ctrl;
  logic       enq;
  logic       in_run;
  logic       not_empty;

  assign head_op   = inst_mem[head_q][6:0];
  assign in_run    = (state_q == ST_RUN);
  assign not_empty = (count_q != '0);

  assign head_is_br   = (head_op == OP_BRANCH);
  assign head_is_ctrl = head_is_br || (head_op == OP_JAL) || (head_op == OP_JALR);
  assign fetch_is_ctrl = (fetch_inst[6:0] == OP_BRANCH) || (fetch_inst[6:0] == OP_JAL) ||
                         (fetch_inst[6:0] == OP_JALR);

  // Stores need no ROB slot; branches are tracked by the branch RS only.
  always_comb begin
    head_needs_rob = 1'b1;
    head_rs_full   = alu_rs_full;
    unique case (head_op)
      OP_BRANCH: begin head_needs_rob = 1'b0; head_rs_full = br_rs_full; end
      OP_LOAD:   begin head_needs_rob = 1'b1; head_rs_full = ls_rs_full; end
      OP_STORE:  begin head_needs_rob = 1'b0; head_rs_full = ls_rs_full; end
      default:   begin head_needs_rob = 1'b1; head_rs_full = alu_rs_full; end
    endcase
    unit_ok = !head_rs_full && !(head_needs_rob && rob_full);
  end

  assign fetch_ready = (count_q < CNT_W'(QDEPTH)) && !ctrl_in_q && in_run;
  assign dec_enable  = not_empty && in_run && unit_ok;
  assign enq         = fetch_valid && fetch_ready;

  assign dec_inst       = inst_mem[head_q];
  assign dec_pc         = pc_mem[head_q];
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign ctrl_pending   = ctrl_pending_q;

  always_comb begin
    head_d  = dec_enable ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (enq && !dec_enable) count_d = count_q + CNT_W'(1);
    else if (!enq && dec_enable) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[tail_q] <= fetch_inst;
      pc_mem[tail_q]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      state_q          <= ST_RUN;
      ctrl_in_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      ctrl_pending_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      unique case (state_q)
        ST_RUN: begin
          redirect_valid_q <= 1'b0;
          if (dec_enable && head_is_ctrl) begin
            if (head_is_br && branch_dest_valid) begin
              state_q          <= ST_REDIR;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= branch_dest;
            end else begin
              state_q        <= ST_WAIT;
              ctrl_pending_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (ctrl_resolve_valid) begin
            state_q          <= ST_REDIR;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= ctrl_resolve_dest;
          end
        end
        ST_REDIR: begin
          state_q          <= ST_RUN;
          redirect_valid_q <= 1'b0;
          ctrl_in_q        <= 1'b0;
          ctrl_pending_q   <= 1'b0;
        end
        default: state_q <= ST_RUN;
      endcase
      // A control inst is always the youngest entry, so enq never overlaps the REDIR clear.
      if (enq && fetch_is_ctrl) ctrl_in_q <= 1'b1;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic stall_rob, stall_rs, stall_ctrl;

  assign stall_rob  = not_empty && in_run && head_needs_rob && rob_full;
  assign stall_rs   = not_empty && in_run && head_rs_full;
  assign stall_ctrl = (state_q == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_rob_cnt  <= '0;
      stall_rs_cnt   <= '0;
      stall_ctrl_cnt <= '0;
    end else begin
      if (stall_rob && (stall_rob_cnt != '1))   stall_rob_cnt  <= stall_rob_cnt + 32'd1;
      if (stall_rs && (stall_rs_cnt != '1))     stall_rs_cnt   <= stall_rs_cnt + 32'd1;
      if (stall_ctrl && (stall_ctrl_cnt != '1)) stall_ctrl_cnt <= stall_ctrl_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a queue-based reference model checked every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        dec_enable;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        rob_full, alu_rs_full, ls_rs_full, br_rs_full;
  logic        branch_dest_valid;
  logic [31:0] branch_dest;
  logic        ctrl_resolve_valid;
  logic [31:0] ctrl_resolve_dest;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ctrl_pending;
`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_rob_cnt, stall_rs_cnt, stall_ctrl_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ALU   = 32'h00100093;
  localparam logic [31:0] I_LOAD  = 32'h00002083;
  localparam logic [31:0] I_STORE = 32'h00112023;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_BNE   = 32'h00001063;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_JALR  = 32'h00008067;

  dispatch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .dec_enable(dec_enable), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .rob_full(rob_full), .alu_rs_full(alu_rs_full), .ls_rs_full(ls_rs_full), .br_rs_full(br_rs_full),
    .branch_dest_valid(branch_dest_valid), .branch_dest(branch_dest),
    .ctrl_resolve_valid(ctrl_resolve_valid), .ctrl_resolve_dest(ctrl_resolve_dest),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ctrl_pending(ctrl_pending)
`ifdef DISPATCH_PERF_EN
    , .stall_rob_cnt(stall_rob_cnt), .stall_rs_cnt(stall_rs_cnt), .stall_ctrl_cnt(stall_ctrl_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: the queue holds in-flight fetches; mode tracks run / waiting for target / redirecting.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  typedef enum int {M_RUN, M_WAIT, M_REDIR} mode_t;
  ent_t        m_q[$];
  mode_t       m_mode = M_RUN;
  bit          m_ctrl_in = 0;
  bit          m_pending = 0;
  logic [31:0] m_rpc = 32'h0;
  ent_t        m_head;
  bit          m_rdy, m_go;
  mode_t       m_pre;

  function automatic bit is_ctrl(input logic [31:0] inst);
    return inst[6:0] == 7'b1100011 || inst[6:0] == 7'b1101111 || inst[6:0] == 7'b1100111;
  endfunction

  function automatic bit unit_ok(input logic [31:0] inst);
    case (inst[6:0])
      7'b1100011: return !br_rs_full;
      7'b0000011: return !ls_rs_full && !rob_full;
      7'b0100011: return !ls_rs_full;
      default:    return !alu_rs_full && !rob_full;
    endcase
  endfunction

  function automatic bit m_ready();
    return (m_q.size() < 4) && !m_ctrl_in && (m_mode == M_RUN);
  endfunction

  function automatic bit m_fire();
    if (m_q.size() == 0 || m_mode != M_RUN) return 1'b0;
    return unit_ok(m_q[0].inst);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_mode = M_RUN;
      m_ctrl_in = 0;
      m_pending = 0;
      m_rpc = 32'h0;
    end else begin
      m_rdy = m_ready();
      m_go  = m_fire();
      m_pre = m_mode;
      if (m_go) begin
        m_head = m_q.pop_front();
        if (is_ctrl(m_head.inst)) begin
          if (m_head.inst[6:0] == 7'b1100011 && branch_dest_valid) begin
            m_mode = M_REDIR;
            m_rpc  = branch_dest;
          end else begin
            m_mode    = M_WAIT;
            m_pending = 1;
          end
        end
      end
      if (m_pre == M_WAIT && ctrl_resolve_valid) begin
        m_mode = M_REDIR;
        m_rpc  = ctrl_resolve_dest;
      end
      if (m_pre == M_REDIR) begin
        m_mode    = M_RUN;
        m_ctrl_in = 0;
        m_pending = 0;
      end
      if (fetch_valid && m_rdy) begin
        m_q.push_back('{inst: fetch_inst, pc: fetch_pc});
        if (is_ctrl(fetch_inst)) m_ctrl_in = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_fetch_ready", {31'b0, fetch_ready}, {31'b0, m_ready()});
    chk("m_dec_enable", {31'b0, dec_enable}, {31'b0, m_fire()});
    if (m_q.size() != 0) begin
      chk("m_dec_inst", dec_inst, m_q[0].inst);
      chk("m_dec_pc", dec_pc, m_q[0].pc);
    end
    chk("m_redirect_valid", {31'b0, redirect_valid}, {31'b0, m_mode == M_REDIR});
    if (m_mode == M_REDIR) chk("m_redirect_pc", redirect_pc, m_rpc);
    chk("m_ctrl_pending", {31'b0, ctrl_pending}, {31'b0, m_pending});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    fetch_valid = v;
    fetch_inst  = inst;
    fetch_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    rob_full = 0; alu_rs_full = 0; ls_rs_full = 0; br_rs_full = 0;
    branch_dest_valid = 0; branch_dest = 0;
    ctrl_resolve_valid = 0; ctrl_resolve_dest = 0;

    @(negedge clk);
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_dec_enable", dec_enable, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_ctrl_pending", ctrl_pending, 0);
    step();
    rst_n = 1'b1;
    step();
    $display("reset done");

    // 1: four ALU instructions back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, I_ALU, 32'h1000 + 32'(4 * i));
      @(negedge clk);
      chk("s1_ready", fetch_ready, 1);
      if (i > 0) begin
        chk("s1_en", dec_enable, 1);
        chk("s1_pc", dec_pc, 32'h1000 + 32'(4 * (i - 1)));
      end else begin
        chk("s1_en_first", dec_enable, 0);
      end
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("s1_en_last", dec_enable, 1);
    chk("s1_pc_last", dec_pc, 32'h100C);
    step();
    @(negedge clk);
    chk("s1_empty", dec_enable, 0);
    chk("s1_ready_end", fetch_ready, 1);
    step();
    $display("scenario 1 alu stream done");

    // 2: fill with rob_full; store dispatches, loads wait for ROB
    rob_full = 1; ls_rs_full = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? I_STORE : I_LOAD, 32'h2000 + 32'(4 * i));
      @(negedge clk);
      chk("s2_fill_ready", fetch_ready, 1);
      chk("s2_fill_en", dec_enable, 0);
      step();
    end
    drive(1'b1, I_ALU, 32'h2010);
    @(negedge clk);
    chk("s2_full_ready", fetch_ready, 0);
    chk("s2_full_en", dec_enable, 0);
    step();
    step();
    ls_rs_full = 0;
    @(negedge clk);
    chk("s2_full_disp_ready", fetch_ready, 0);
    chk("s2_store_en", dec_enable, 1);
    chk("s2_store_pc", dec_pc, 32'h2000);
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("s2_load_stall", dec_enable, 0);
    chk("s2_load_pc", dec_pc, 32'h2004);
    chk("s2_ready_after", fetch_ready, 1);
    step();
    step();
    rob_full = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("s2_load_en", dec_enable, 1);
      chk("s2_load_pc_seq", dec_pc, 32'h2004 + 32'(4 * j));
      step();
    end
    @(negedge clk);
    chk("s2_drained", dec_enable, 0);
    step();
    $display("scenario 2 rob stall done");

    // 3: BEQ with target known at dispatch
    drive(1'b1, I_BEQ, 32'h3000);
    step();
    drive(1'b1, I_ALU, 32'h3004);
    branch_dest_valid = 1; branch_dest = 32'h100;
    @(negedge clk);
    chk("s3_en", dec_enable, 1);
    chk("s3_inst", dec_inst, I_BEQ);
    chk("s3_ready_blocked", fetch_ready, 0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    branch_dest_valid = 0;
    @(negedge clk);
    chk("s3_redir_valid", redirect_valid, 1);
    chk("s3_redir_pc", redirect_pc, 32'h100);
    chk("s3_pending", ctrl_pending, 0);
    step();
    @(negedge clk);
    chk("s3_redir_once", redirect_valid, 0);
    chk("s3_ready_back", fetch_ready, 1);
    chk("s3_dropped", dec_enable, 0);
    step();
    $display("scenario 3 beq redirect done");

    // 4: JALR waits ten cycles for resolution
    drive(1'b1, I_JALR, 32'h4000);
    step();
    drive(1'b1, I_ALU, 32'h4004);
    @(negedge clk);
    chk("s4_en", dec_enable, 1);
    step();
    for (int k = 0; k < 10; k++) begin
      if (k == 9) begin
        ctrl_resolve_valid = 1; ctrl_resolve_dest = 32'h2C;
      end
      @(negedge clk);
      chk("s4_wait_ready", fetch_ready, 0);
      chk("s4_wait_en", dec_enable, 0);
      chk("s4_wait_pending", ctrl_pending, 1);
      chk("s4_wait_rv", redirect_valid, 0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    ctrl_resolve_dest = 32'h55;
    @(negedge clk);
    chk("s4_rv", redirect_valid, 1);
    chk("s4_rpc", redirect_pc, 32'h2C);
    step();
    ctrl_resolve_valid = 0;
    @(negedge clk);
    chk("s4_rv_once", redirect_valid, 0);
    chk("s4_pending_clr", ctrl_pending, 0);
    chk("s4_ready_back", fetch_ready, 1);
    step();
    $display("scenario 4 jalr wait done");

    // 5: BNE blocks fetch; resolve in RUN ignored
    drive(1'b1, I_BNE, 32'h5000);
    br_rs_full = 1;
    ctrl_resolve_valid = 1; ctrl_resolve_dest = 32'h77;
    step();
    drive(1'b1, I_ALU, 32'h5004);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("s5_en_blocked", dec_enable, 0);
      chk("s5_ready_blocked", fetch_ready, 0);
      chk("s5_no_redirect", redirect_valid, 0);
      step();
    end
    br_rs_full = 0; ctrl_resolve_valid = 0;
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("s5_en", dec_enable, 1);
    chk("s5_pc", dec_pc, 32'h5000);
    chk("s5_no_redirect2", redirect_valid, 0);
    step();
    ctrl_resolve_valid = 1; ctrl_resolve_dest = 32'h88;
    @(negedge clk);
    chk("s5_pending", ctrl_pending, 1);
    step();
    ctrl_resolve_valid = 0;
    @(negedge clk);
    chk("s5_rv", redirect_valid, 1);
    chk("s5_rpc", redirect_pc, 32'h88);
    step();
    drive(1'b1, I_ALU, 32'h5008);
    @(negedge clk);
    chk("s5_ready", fetch_ready, 1);
    chk("s5_empty", dec_enable, 0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("s5_after_en", dec_enable, 1);
    chk("s5_after_pc", dec_pc, 32'h5008);
    step();
    $display("scenario 5 bne fetch block done");

    // 6: reset asserted while waiting on JAL
    drive(1'b1, I_JAL, 32'h6000);
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("s6_en", dec_enable, 1);
    step();
    ctrl_resolve_valid = 1; ctrl_resolve_dest = 32'h99;
    @(negedge clk);
    chk("s6_wait", ctrl_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_ready", fetch_ready, 1);
    chk("s6_rst_en", dec_enable, 0);
    chk("s6_rst_rv", redirect_valid, 0);
    chk("s6_rst_rpc", redirect_pc, 0);
    chk("s6_rst_pending", ctrl_pending, 0);
    ctrl_resolve_valid = 0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_post_rv", redirect_valid, 0);
    chk("s6_post_pending", ctrl_pending, 0);
`ifdef DISPATCH_PERF_EN
    chk("s6_cnt_rob", stall_rob_cnt, 0);
    chk("s6_cnt_rs", stall_rs_cnt, 0);
    chk("s6_cnt_ctrl", stall_ctrl_cnt, 0);
`endif
    step();
    drive(1'b1, I_ALU, 32'h7000);
    @(negedge clk);
    chk("s6_enq_ready", fetch_ready, 1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("s6_enq_en", dec_enable, 1);
    chk("s6_enq_pc", dec_pc, 32'h7000);
    step();
    step();
    $display("scenario 6 reset in wait done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
